// File: rtl/wb_write_port.sv
// Writeback-port arbiter: pipeline result wins, long-latency results drain in order through a small FIFO.
// Optional feature macro: WB_PEND_MASK_EN (builds the per-register pending mask for the hazard unit).
module wb_write_port #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     pend_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic            vld;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t [DEPTH-1:0] fifo, fifo_n;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    count;

    logic full, empty, lu_hs, pipe_sel, pop, bypass, push;
    ent_t head_e;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        lu_ready = !full;
        lu_hs    = lu_valid && lu_ready;
        pipe_sel = pipe_valid && (pipe_rd != 5'd0);
        pop      = !pipe_sel && !empty;
        bypass   = !pipe_sel && empty && lu_hs && (lu_rd != 5'd0);
        push     = lu_hs && (lu_rd != 5'd0) && !bypass;
        head_e   = fifo[head];
    end

    // Kill is applied after the push so a same-cycle LU result to the same rd dies too.
    always_comb begin
        fifo_n = fifo;
        if (pop)
            fifo_n[head].vld = 1'b0;
        if (push)
            fifo_n[tail] = '{vld: 1'b1, rd: lu_rd, data: lu_data};
        if (pipe_sel) begin
            for (int i = 0; i < DEPTH; i++)
                if (fifo_n[i].rd == pipe_rd)
                    fifo_n[i].vld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo    <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            fifo  <= fifo_n;
            head  <= head + AW'(pop);
            tail  <= tail + AW'(push);
            count <= count + CW'(push) - CW'(pop);
            wb_we <= pipe_sel || bypass || (pop && head_e.vld);
            if (pipe_sel) begin
                wb_rd   <= pipe_rd;
                wb_data <= pipe_data;
            end else if (pop) begin
                wb_rd   <= head_e.rd;
                wb_data <= head_e.data;
            end else if (bypass) begin
                wb_rd   <= lu_rd;
                wb_data <= lu_data;
            end
        end
    end

`ifdef WB_PEND_MASK_EN
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (fifo[i].vld)
                pend_mask[fifo[i].rd] = 1'b1;
        pend_mask[0] = 1'b0;
    end
`else
    assign pend_mask = 32'h0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Scoreboard bench for wb_write_port: expected writes are queued at stimulus time, a negedge monitor retires them.
module tb_wb_write_port;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pipe_valid = 1'b0;
    logic [4:0]      pipe_rd = '0;
    logic [XLEN-1:0] pipe_data = '0;
    logic            lu_valid = 1'b0;
    logic [4:0]      lu_rd = '0;
    logic [XLEN-1:0] lu_data = '0;
    logic            lu_ready;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     pend_mask;

    int total = 0;
    int bad   = 0;
    logic [4+XLEN:0] exp_q[$];

    wb_write_port #(.DEPTH(2), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pm(input logic [31:0] m);
`ifdef WB_PEND_MASK_EN
        return m;
`else
        return 32'h0 & m;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] d);
        exp_q.push_back({1'b1, rd, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        lu_valid   = 1'b0; lu_rd   = '0; lu_data   = '0;
    endtask

    // Monitor: every asserted write must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h want none", wb_rd, wb_data);
            end else begin
                logic [4+XLEN:0] e;
                e = exp_q.pop_front();
                if (wb_rd !== e[XLEN+4:XLEN] || wb_data !== e[XLEN-1:0]) begin
                    bad++;
                    $display("FAIL write: got rd=%0d data=%h want rd=%0d data=%h",
                             wb_rd, wb_data, e[XLEN+4:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    bit          rdy_t[8];
    logic [31:0] pm_t[8];

    initial begin
        int li;
        rdy_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        pm_t  = '{32'h0, 32'h1 << 20, (32'h1 << 20) | (32'h1 << 21), (32'h1 << 20) | (32'h1 << 21),
                  (32'h1 << 20) | (32'h1 << 21), 32'h1 << 21, 32'h1 << 22, 32'h0};

        // Reset state
        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_ready", {31'd0, lu_ready}, 32'd1);
        chk("rst_pend", pend_mask, 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Bypass: empty FIFO, idle pipe
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'h11;
        expect_wr(5'd5, 32'h11);
        tick(); idle();
        chk("byp_ready", {31'd0, lu_ready}, 32'd1);
        chk("byp_pend", pend_mask, 32'd0);
        tick();

        // Pipe and LU collide: pipe first, LU next cycle
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hB;
        expect_wr(5'd3, 32'hA);
        expect_wr(5'd7, 32'hB);
        tick(); idle();
        chk("col_pend_t1", pend_mask, pm(32'h1 << 7));
        chk("col_ready_t1", {31'd0, lu_ready}, 32'd1);
        tick();
        chk("col_pend_t2", pend_mask, 32'd0);
        tick();

        // Four pipe writes, three LU results, DEPTH=2 back-pressure
        for (int c = 0; c < 4; c++) expect_wr(5'(10 + c), 32'h100 + c);
        for (int c = 0; c < 3; c++) expect_wr(5'(20 + c), 32'h200 + c);
        li = 0;
        for (int c = 0; c < 8; c++) begin
            pipe_valid = (c < 4); pipe_rd = (c < 4) ? 5'(10 + c) : 5'd0; pipe_data = 32'h100 + c;
            lu_valid = (li < 3); lu_rd = 5'(20 + li); lu_data = 32'h200 + li;
            #1;
            chk($sformatf("bp_ready_c%0d", c), {31'd0, lu_ready}, {31'd0, rdy_t[c]});
            chk($sformatf("bp_pend_c%0d", c), pend_mask, pm(pm_t[c]));
            if (lu_valid && rdy_t[c]) li++;
            tick();
        end
        idle();
        tick();

        // WAW kill of a buffered entry
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        expect_wr(5'd4, 32'h44);
        tick();
        chk("waw_pend_buf", pend_mask, pm(32'h1 << 9));
        lu_valid = 1'b0; pipe_rd = 5'd9; pipe_data = 32'h55;
        expect_wr(5'd9, 32'h55);
        tick(); idle();
        chk("waw_pend_kill", pend_mask, 32'd0);
        tick();
        chk("waw_killed_pop_we", {31'd0, wb_we}, 32'd0);
        chk("waw_ready", {31'd0, lu_ready}, 32'd1);
        tick();

        // WAW kill of an LU result pushed in the same cycle
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h66;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h77;
        expect_wr(5'd9, 32'h66);
        tick(); idle();
        chk("waw_same_pend", pend_mask, 32'd0);
        tick();
        chk("waw_same_we", {31'd0, wb_we}, 32'd0);
        tick();

        // x0 from both sources is ignored
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFF;
        tick();
        chk("x0_we_1", {31'd0, wb_we}, 32'd0);
        chk("x0_pend_1", pend_mask, 32'd0);
        tick();
        chk("x0_we_2", {31'd0, wb_we}, 32'd0);
        chk("x0_ready", {31'd0, lu_ready}, 32'd1);
        idle();
        tick();

        // Reset with two buffered entries
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        lu_valid = 1'b1; lu_rd = 5'd2; lu_data = 32'h2;
        expect_wr(5'd1, 32'h1);
        tick();
        pipe_rd = 5'd3; pipe_data = 32'h3; lu_rd = 5'd4; lu_data = 32'h4;
        expect_wr(5'd3, 32'h3);
        tick(); idle();
        chk("rstm_ready_full", {31'd0, lu_ready}, 32'd0);
        chk("rstm_pend_full", pend_mask, pm((32'h1 << 2) | (32'h1 << 4)));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstm_we", {31'd0, wb_we}, 32'd0);
        chk("rstm_ready", {31'd0, lu_ready}, 32'd1);
        chk("rstm_pend", pend_mask, 32'd0);
        tick(); tick();
        @(negedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
